// File: rtl/fifo_readback_checker_if.sv
// FIFO read-port bundle as seen by the readback checker.
// The checker only observes rd_en and dout; it never drives them.
interface fifo_readback_checker_if #(
  parameter int DATA_W = 4
) ();
  logic              rd_en;
  logic [DATA_W-1:0] dout;

  modport master (output rd_en, output dout);
  modport slave  (input  rd_en, input  dout);
endinterface

// File: rtl/fifo_readback_checker.sv
// Captures FIFO readback words for each trigger run and checks them against a fixed pattern.
// Reports pass/fail/timeout/overrun and keeps saturating run counters for soak tests.
module fifo_readback_checker #(
  parameter int                          DATA_W       = 4,
  parameter int                          NUM_WORDS    = 2,
  parameter logic [NUM_WORDS*DATA_W-1:0] EXP_PATTERN  = {4'b1110, 4'b1001},
  parameter int                          READ_LATENCY = 1,
  parameter logic [26:0]                 TIMEOUT      = 27'd124999999
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   trig_in,
  fifo_readback_checker_if.slave fifo,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   fail,
  output logic                   timeout,
  output logic                   overrun,
  output logic [NUM_WORDS-1:0]   mismatch_mask,
  output logic [3:0]             word_cnt,
  output logic [7:0]             pass_cnt,
  output logic [7:0]             fail_cnt
);

  localparam int IW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, CHECK, DONE} state_t;

  state_t                   state, state_d;
  logic                     trig_q, arm;
  logic [READ_LATENCY-1:0]  vld_pipe;
  logic                     cap_stb;
  logic [26:0]              timer, timer_d;
  logic [DATA_W-1:0]        cap_buf [NUM_WORDS];
  logic [NUM_WORDS-1:0]     cmp;
  logic [IW-1:0]            wr_idx;
  logic                     wr_en;

  logic                     busy_d, done_d, pass_d, fail_d, timeout_d, overrun_d;
  logic [NUM_WORDS-1:0]     mask_d;
  logic [3:0]               cnt_d;
  logic [7:0]               pass_cnt_d, fail_cnt_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign arm     = trig_in & ~trig_q;
  assign cap_stb = vld_pipe[READ_LATENCY-1];
  assign wr_idx  = word_cnt[IW-1:0];

  // one comparator per expected word
  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_cmp
    assign cmp[k] = (cap_buf[k] != EXP_PATTERN[k*DATA_W +: DATA_W]);
  end

  always_comb begin
    state_d    = state;
    busy_d     = busy;
    done_d     = done;
    pass_d     = pass;
    fail_d     = fail;
    timeout_d  = timeout;
    overrun_d  = overrun;
    mask_d     = mismatch_mask;
    cnt_d      = word_cnt;
    timer_d    = timer;
    pass_cnt_d = pass_cnt;
    fail_cnt_d = fail_cnt;
    wr_en      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (arm) begin
          // a strobe landing on the arm edge is dropped, not flagged
          state_d   = CAPTURE;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          fail_d    = 1'b0;
          timeout_d = 1'b0;
          overrun_d = 1'b0;
          mask_d    = '0;
          cnt_d     = '0;
          timer_d   = '0;
        end else if (state == DONE && cap_stb) begin
          overrun_d = 1'b1;
        end
      end
      CAPTURE: begin
        timer_d = timer + 27'd1;
        if (cap_stb) begin
          wr_en = 1'b1;
          cnt_d = word_cnt + 4'd1;
        end
        // final capture beats a simultaneous timeout
        if (cap_stb && cnt_d == 4'(NUM_WORDS)) begin
          state_d = CHECK;
        end else if (timer == TIMEOUT - 27'd1) begin
          state_d    = DONE;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          timeout_d  = 1'b1;
          fail_d     = 1'b1;
          fail_cnt_d = sat_inc(fail_cnt);
        end
      end
      CHECK: begin
        mask_d  = cmp;
        pass_d  = (cmp == '0);
        fail_d  = (cmp != '0);
        if (cmp == '0) pass_cnt_d = sat_inc(pass_cnt);
        else           fail_cnt_d = sat_inc(fail_cnt);
        if (cap_stb) overrun_d = 1'b1;
        state_d = DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= IDLE;
      trig_q        <= 1'b0;
      vld_pipe      <= '0;
      timer         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      fail          <= 1'b0;
      timeout       <= 1'b0;
      overrun       <= 1'b0;
      mismatch_mask <= '0;
      word_cnt      <= '0;
      pass_cnt      <= '0;
      fail_cnt      <= '0;
      for (int i = 0; i < NUM_WORDS; i++) cap_buf[i] <= '0;
    end else begin
      state         <= state_d;
      trig_q        <= trig_in;
      vld_pipe      <= READ_LATENCY'({vld_pipe, fifo.rd_en});
      timer         <= timer_d;
      busy          <= busy_d;
      done          <= done_d;
      pass          <= pass_d;
      fail          <= fail_d;
      timeout       <= timeout_d;
      overrun       <= overrun_d;
      mismatch_mask <= mask_d;
      word_cnt      <= cnt_d;
      pass_cnt      <= pass_cnt_d;
      fail_cnt      <= fail_cnt_d;
      if (wr_en) cap_buf[wr_idx] <= fifo.dout;
    end
  end

endmodule

// File: tb/tb_fifo_readback_checker.sv
// Directed bench for fifo_readback_checker (TIMEOUT shortened to 20 cycles).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_fifo_readback_checker;
  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       trig_in = 1'b0;
  logic       busy, done, pass, fail, timeout, overrun;
  logic [1:0] mismatch_mask;
  logic [3:0] word_cnt;
  logic [7:0] pass_cnt, fail_cnt;
  int         total = 0;
  int         bad = 0;

  fifo_readback_checker_if #(.DATA_W(4)) fifo ();

  fifo_readback_checker #(
    .DATA_W(4), .NUM_WORDS(2), .EXP_PATTERN({4'b1110, 4'b1001}),
    .READ_LATENCY(1), .TIMEOUT(27'd20)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .trig_in(trig_in), .fifo(fifo),
    .busy(busy), .done(done), .pass(pass), .fail(fail),
    .timeout(timeout), .overrun(overrun), .mismatch_mask(mismatch_mask),
    .word_cnt(word_cnt), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  // raise trig for one edge; returns one cycle after the arm edge
  task automatic arm_run();
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
  endtask

  // rd_en on arm+7.. for n cycles, data one cycle later; optional trig pulse on arm+8
  task automatic reads(input int n, input logic [3:0] d0, d1, d2, input bit pulse);
    repeat (6) tick();
    fifo.rd_en = 1'b1;
    tick();
    fifo.dout  = d0;
    fifo.rd_en = (n > 1);
    if (pulse) trig_in = 1'b1;
    tick();
    fifo.dout  = d1;
    fifo.rd_en = (n > 2);
    trig_in    = 1'b0;
    tick();
    fifo.dout  = d2;
    fifo.rd_en = 1'b0;
  endtask

  initial begin
    fifo.rd_en = 1'b0;
    fifo.dout  = 4'h0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_cnt", word_cnt, 0);
    chk("rst_pcnt", pass_cnt, 0);
    RST_N = 1'b1;
    tick();

    // matching run
    arm_run();
    chk("def_busy_arm", busy, 1);
    chk("def_cnt_arm", word_cnt, 0);
    reads(2, 4'h9, 4'hE, 4'h0, 0);
    chk("def_cnt_chk", word_cnt, 2);
    chk("def_busy_chk", busy, 1);
    chk("def_done_chk", done, 0);
    tick();
    chk("def_done", done, 1);
    chk("def_pass", pass, 1);
    chk("def_fail", fail, 0);
    chk("def_mask", mismatch_mask, 2'b00);
    chk("def_pcnt", pass_cnt, 1);
    chk("def_busy", busy, 0);

    // word 1 wrong
    arm_run();
    chk("mis_done_clr", done, 0);
    reads(2, 4'h9, 4'hF, 4'h0, 0);
    tick();
    chk("mis_fail", fail, 1);
    chk("mis_pass", pass, 0);
    chk("mis_mask", mismatch_mask, 2'b10);
    chk("mis_fcnt", fail_cnt, 1);
    chk("mis_tmo", timeout, 0);

    // third strobe lands in CHECK
    arm_run();
    reads(3, 4'h9, 4'hE, 4'h3, 0);
    tick();
    chk("ovr_pass", pass, 1);
    chk("ovr_flag", overrun, 1);
    chk("ovr_pcnt", pass_cnt, 2);
    repeat (2) tick();
    chk("ovr_hold_pass", pass, 1);
    chk("ovr_hold_flag", overrun, 1);

    // next arm clears overrun; single read then timeout
    arm_run();
    chk("tmo_ovr_clr", overrun, 0);
    chk("tmo_pass_clr", pass, 0);
    reads(1, 4'h9, 4'h0, 4'h0, 0);
    repeat (10) tick();
    chk("tmo_done_pre", done, 0);
    chk("tmo_busy_pre", busy, 1);
    tick();
    chk("tmo_done", done, 1);
    chk("tmo_flag", timeout, 1);
    chk("tmo_fail", fail, 1);
    chk("tmo_cnt", word_cnt, 1);
    chk("tmo_mask", mismatch_mask, 2'b00);
    chk("tmo_fcnt", fail_cnt, 2);

    // trig pulses in CAPTURE and CHECK must be ignored
    arm_run();
    reads(2, 4'h9, 4'hE, 4'h0, 1);
    chk("tog_cnt_chk", word_cnt, 2);
    trig_in = 1'b1;
    tick();
    trig_in = 1'b0;
    chk("tog_done", done, 1);
    chk("tog_pass", pass, 1);
    chk("tog_cnt", word_cnt, 2);
    chk("tog_pcnt", pass_cnt, 3);
    tick();
    chk("tog_busy", busy, 0);

    // reset after one capture
    arm_run();
    reads(1, 4'h9, 4'h0, 4'h0, 0);
    chk("mrst_cnt_pre", word_cnt, 1);
    RST_N = 1'b0;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_cnt", word_cnt, 0);
    chk("mrst_pcnt", pass_cnt, 0);
    chk("mrst_fcnt", fail_cnt, 0);
    tick();
    RST_N = 1'b1;
    tick();
    arm_run();
    reads(2, 4'h9, 4'hE, 4'h0, 0);
    tick();
    chk("mrst_pass", pass, 1);
    chk("mrst_pcnt2", pass_cnt, 1);

    // fail counter saturation
    for (int i = 0; i < 260; i++) begin
      arm_run();
      reads(2, 4'h9, 4'hF, 4'h0, 0);
      tick();
      if (i == 253) chk("sat_254", fail_cnt, 254);
      if (i == 254) chk("sat_255", fail_cnt, 255);
    end
    chk("sat_fcnt", fail_cnt, 255);
    chk("sat_pcnt", pass_cnt, 1);
    chk("sat_mask", mismatch_mask, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule

// File: doc/fifo_readback_checker.md
Name: fifo_readback_checker

Overview:
Downstream consumer of the FIFO read port on the Zybo ILA test path. It watches rd_en and dout and, for each trigger run, captures the words read back after the FIFO read latency. It compares the captured words against the expected write pattern and reports pass, fail, timeout and overrun on status/LED outputs, with saturating run counters for soak testing.

Parameters:
DATA_W, 4, FIFO data width.
NUM_WORDS, 2, words expected per run (1..15).
EXP_PATTERN, {4'b1110,4'b1001}, packed expected words; word k occupies bits [k*DATA_W +: DATA_W], word 0 in the LSBs.
READ_LATENCY, 1, cycles from rd_en high to valid dout (1..4).
TIMEOUT, 27'd124999999, cycles allowed from arm to last capture.

Ports:
CLK  in  1  system clock
RST_N  in  1  asynchronous active-low reset
trig_in  in  1  run trigger, level; a rising edge arms a run
rd_en  in  1  FIFO read enable, observed only
dout  in  DATA_W  FIFO read data
busy  out  1  run in progress (CAPTURE or CHECK)
done  out  1  result valid; held until next arm
pass  out  1  all words matched
fail  out  1  mismatch or timeout
timeout  out  1  TIMEOUT expired before NUM_WORDS captures
overrun  out  1  sticky: capture strobe after the run completed
mismatch_mask  out  NUM_WORDS  bit k set when word k differed
word_cnt  out  4  words captured this run
pass_cnt  out  8  runs passed, saturates at 255
fail_cnt  out  8  runs failed, saturates at 255

Behaviour:
- Reset (RST_N low, async): state IDLE; all outputs 0; capture buffer, index, timer, rd_en pipeline and trigger register cleared. Reset mid-run aborts the run and does not increment any counter.
- Trigger: trig_q <= trig_in each cycle; arm = trig_in & ~trig_q. arm is honoured only in IDLE or DONE and is ignored in CAPTURE or CHECK.
- Capture strobe: rd_en is delayed through READ_LATENCY flops; cap_stb is the last stage. The pipeline runs in every state.
- On arm, in the next cycle:
  - state becomes CAPTURE, busy=1.
  - done, pass, fail, timeout, overrun, mismatch_mask, word_cnt and timer are set to 0.
  - A cap_stb coinciding with the arm cycle is discarded and does not set overrun.
- CAPTURE:
  - Each cap_stb stores dout at index word_cnt, then word_cnt increments.
  - timer increments every cycle.
  - When word_cnt reaches NUM_WORDS after a capture, the next state is CHECK.
  - If timer reaches TIMEOUT-1 with word_cnt < NUM_WORDS, go to DONE with timeout=1, fail=1, fail_cnt+1. mismatch_mask stays 0.
  - If the final capture and timeout occur in the same cycle, the capture wins and the state goes to CHECK.
- CHECK (one cycle, busy=1):
  - mismatch_mask[k] = (buf[k] != expected word k).
  - pass = (mask == 0); fail = !pass.
  - Increment pass_cnt or fail_cnt (saturating).
  - Next state DONE.
- DONE: busy=0, done=1. pass, fail, timeout, mismatch_mask and word_cnt hold. Any cap_stb in CHECK or DONE sets overrun (sticky until next arm) and is not stored; it does not change pass or fail.
- IDLE: cap_stb is ignored; overrun is not set.
- Latency: the last cap_stb at cycle n gives CHECK at n+1 and done/pass/fail valid from n+2.
- All outputs are registered. Counters never wrap.

Test Plan:
- Defaults:
  - Reset, then trig_in 0->1.
  - rd_en high on arm+7 and arm+8; dout = 9 then E, one cycle after each rd_en.
  - Required: word_cnt=2, then pass=1, fail=0, mask=2'b00, done=1, pass_cnt=1, busy low after CHECK.
- Data mismatch: same stimulus with dout = 9 then F -> fail=1, pass=0, mismatch_mask=2'b10, fail_cnt=1, timeout=0.
- Timeout (TIMEOUT=20): a single read -> at arm+20 done=1, timeout=1, fail=1, word_cnt=1, mismatch_mask=0.
- Overrun: three reads in a row with correct first two words -> pass=1, then overrun=1 one cycle after the third strobe. pass stays 1; the next arm clears overrun.
- Reset mid-run: RST_N low after one capture -> all outputs 0 immediately, counters 0. After release, a new trigger run with correct data -> pass=1, pass_cnt=1.
- Saturation and re-arm: 260 failing runs -> fail_cnt=255. Toggling trig_in during CAPTURE has no effect on state or results.
